// File: rtl/memory_responder_if.sv
// Request/response bus between a requester and memory_responder.
// The master side issues start/address/mode/store data. The slave side returns the load result and status.
interface memory_responder_if;
    logic        start;
    logic [31:0] address;
    logic [2:0]  mode;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done;
    logic        active;
    logic        error;

    modport master (
        output start, address, mode, write_enable, write_data,
        input  read_data, done, active, error
    );

    modport slave (
        input  start, address, mode, write_enable, write_data,
        output read_data, done, active, error
    );
endinterface

// File: rtl/memory_responder.sv
// Single-request memory responder with programmable wait latency and RISC-V style byte/half/word access.
// Optional macro MEMORY_RESPONDER_MISALIGNED_EN serves word-crossing accesses as two back-to-back RAM accesses.
module memory_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic         clk,
    input  logic         rst,
    memory_responder_if.slave bus
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        ACCESS0 = 3'd2,
        ACCESS1 = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_r;
    logic [3:0]  wait_cnt_r;
    logic [31:0] addr_r;
    logic [2:0]  mode_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [31:0] lo_r;
    logic [31:0] read_data_r;
    logic        done_r;
    logic        active_r;
    logic        error_r;

    logic [31:0] mem_r [MEM_WORDS];

    logic [2:0]    size_s;
    logic [3:0]    base_mask_s;
    logic [7:0]    bmask_s;
    logic [63:0]   data64_s;
    logic [32:0]   end_s;
    logic          oob_s;
    logic          cross_s;
    logic          bad_mode_s;
    logic          misalign_err_s;
    logic          split_s;
    logic          req_err_s;
    logic [AW-1:0] idx0_s;
    logic [AW-1:0] idx1_s;
    logic [31:0]   rd_word_s;
    logic [63:0]   raw64_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [3:0]    wr_mask_s;
    logic [31:0]   wr_data_s;

    // Pick the addressed lanes out of a two-word window and sign/zero extend them.
    function automatic logic [31:0] load_extend(input logic [63:0] raw, input logic [1:0] offset,
                                                input logic [2:0] mode);
        logic [31:0] sh;
        sh = 32'(raw >> {offset, 3'b000});
        case (mode)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extend = {24'd0, sh[7:0]};
            3'b101:  load_extend = {16'd0, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    assign idx0_s    = addr_r[AW+1:2];
    assign idx1_s    = idx0_s + AW'(1);
    assign rd_word_s = mem_r[(state_r == ACCESS1) ? idx1_s : idx0_s];

    // Decode the latched request: byte lanes, shifted store data, range and legality.
    always_comb begin
        size_s      = 3'd4;
        base_mask_s = 4'b1111;
        case (mode_r[1:0])
            2'b00: begin
                size_s      = 3'd1;
                base_mask_s = 4'b0001;
            end
            2'b01: begin
                size_s      = 3'd2;
                base_mask_s = 4'b0011;
            end
            default: begin
                size_s      = 3'd4;
                base_mask_s = 4'b1111;
            end
        endcase
        bmask_s    = {4'd0, base_mask_s} << addr_r[1:0];
        data64_s   = {32'd0, wdata_r} << {addr_r[1:0], 3'b000};
        end_s      = {1'b0, addr_r} + {30'd0, size_s} - 33'd1;
        oob_s      = (end_s >= MEM_BYTES);
        cross_s    = |bmask_s[7:4];
        bad_mode_s = (mode_r == 3'b011) || (mode_r[2:1] == 2'b11);
`ifdef MEMORY_RESPONDER_MISALIGNED_EN
        misalign_err_s = 1'b0;
        split_s        = cross_s;
`else
        misalign_err_s = cross_s || ((mode_r[1:0] == 2'b01) && addr_r[0]);
        split_s        = 1'b0;
`endif
        req_err_s = bad_mode_s || (we_r && mode_r[2]) || oob_s || misalign_err_s;
    end

    // Route the store for the current access phase and assemble the load window.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = idx0_s;
        wr_mask_s = 4'd0;
        wr_data_s = 32'd0;
        if ((state_r == ACCESS0) && we_r && !req_err_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = idx0_s;
            wr_mask_s = bmask_s[3:0];
            wr_data_s = data64_s[31:0];
        end else if ((state_r == ACCESS1) && we_r) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = idx1_s;
            wr_mask_s = bmask_s[7:4];
            wr_data_s = data64_s[63:32];
        end else begin
            wr_en_s   = 1'b0;
        end
        if (state_r == ACCESS1) begin
            raw64_s = {rd_word_s, lo_r};
        end else begin
            raw64_s = {32'd0, rd_word_s};
        end
    end

    // Backing RAM with byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask_s[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Request sequencer with registered status and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            addr_r      <= 32'd0;
            mode_r      <= 3'd0;
            we_r        <= 1'b0;
            wdata_r     <= 32'd0;
            lo_r        <= 32'd0;
            read_data_r <= 32'd0;
            done_r      <= 1'b0;
            active_r    <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        addr_r     <= bus.address;
                        mode_r     <= bus.mode;
                        we_r       <= bus.write_enable;
                        wdata_r    <= bus.write_data;
                        wait_cnt_r <= WAIT_INIT;
                        active_r   <= 1'b1;
                        state_r    <= (LATENCY == 0) ? ACCESS0 : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r <= ACCESS0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ACCESS0: begin
                    if (req_err_s) begin
                        error_r <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (split_s) begin
                        lo_r    <= rd_word_s;
                        state_r <= ACCESS1;
                    end else begin
                        if (!we_r) begin
                            read_data_r <= load_extend(raw64_s, addr_r[1:0], mode_r);
                        end
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                ACCESS1: begin
                    if (!we_r) begin
                        read_data_r <= load_extend(raw64_s, addr_r[1:0], mode_r);
                    end
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    active_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    active_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign bus.read_data = read_data_r;
    assign bus.done      = done_r;
    assign bus.active    = active_r;
    assign bus.error     = error_r;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder (LATENCY=2, MEM_WORDS=1024); expectations are hand-computed.
// Build with MEMORY_RESPONDER_MISALIGNED_EN defined to exercise the split-access expectations.
module tb_memory_responder;

    localparam int L = 2;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rd;
        int          due;
        int          act;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   act_cnt = 0;
    exp_t q[$];
    exp_t mon_e;

    memory_responder_if bus ();

    memory_responder #(.MEM_WORDS(1024), .LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst) begin
            act_cnt = 0;
        end else begin
            if (bus.active) act_cnt++;
            if (bus.done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk({mon_e.name, "_err"}, 32'(bus.error), 32'(mon_e.err));
                    chk({mon_e.name, "_rd"}, bus.read_data, mon_e.rd);
                    chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
                    chk({mon_e.name, "_active"}, 32'(act_cnt), 32'(mon_e.act));
                end
                act_cnt = 0;
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [2:0] md,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input int extra, input bit noise);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.write_enable = we;
        bus.mode         = md;
        bus.address      = addr;
        bus.write_data   = wd;
        e.name = name;
        e.err  = exp_err;
        e.rd   = exp_rd;
        e.due  = cyc + 2 + L + extra;
        e.act  = 2 + L + extra;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
            if (noise && n < 3) begin
                bus.start        = 1'b1;
                bus.address      = 32'h0000_0020;
                bus.write_enable = 1'b1;
                bus.mode         = 3'b010;
                bus.write_data   = 32'hBAD0_BAD0;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done want done", name);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_bad;
        bus.start        = 1'b0;
        bus.address      = 32'd0;
        bus.mode         = 3'd0;
        bus.write_enable = 1'b0;
        bus.write_data   = 32'd0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rd", bus.read_data, 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_active", 32'(bus.active), 32'h0);
        chk("reset_error", 32'(bus.error), 32'h0);

        issue("sw_10",    1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 0, 1'b0);
        issue("lw_10",    1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 0, 1'b0);
        issue("lb_13",    1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 0, 1'b0);
        issue("lbu_13",   1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h000000DE, 0, 1'b0);
        issue("lh_10",    1'b0, 3'b001, 32'h10, 32'h0,        1'b0, 32'hFFFFBEEF, 0, 1'b0);
        issue("lhu_12",   1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h0000DEAD, 0, 1'b0);
        issue("lh_12",    1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFFDEAD, 0, 1'b0);
        issue("sb_11",    1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 1'b0, 32'hFFFFDEAD, 0, 1'b0);
        issue("lw_10b",   1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 0, 1'b0);
        issue("sw_14",    1'b1, 3'b010, 32'h14, 32'hFFFFFFFF, 1'b0, 32'hDEAD55EF, 0, 1'b0);
        issue("sh_16",    1'b1, 3'b001, 32'h16, 32'hAAAA7788, 1'b0, 32'hDEAD55EF, 0, 1'b0);
        issue("lw_14",    1'b0, 3'b010, 32'h14, 32'h0,        1'b0, 32'h7788FFFF, 0, 1'b0);
        issue("lw_oob",   1'b0, 3'b010, 32'h1000, 32'h0,      1'b1, 32'h7788FFFF, 0, 1'b0);
        issue("mode_011", 1'b0, 3'b011, 32'h0,  32'h0,        1'b1, 32'h7788FFFF, 0, 1'b0);
        issue("st_m100",  1'b1, 3'b100, 32'h14, 32'h0,        1'b1, 32'h7788FFFF, 0, 1'b0);
        issue("lw_14b",   1'b0, 3'b010, 32'h14, 32'h0,        1'b0, 32'h7788FFFF, 0, 1'b0);
        issue("sw_ffc",   1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 1'b0, 32'h7788FFFF, 0, 1'b0);
        issue("lw_ffc",   1'b0, 3'b010, 32'hFFC, 32'h0,       1'b0, 32'h0BADF00D, 0, 1'b0);
        issue("sh_fff",   1'b1, 3'b001, 32'hFFF, 32'h0,       1'b1, 32'h0BADF00D, 0, 1'b0);
        issue("lb_1000",  1'b0, 3'b000, 32'h1000, 32'h0,      1'b1, 32'h0BADF00D, 0, 1'b0);
        issue("lbu_fff",  1'b0, 3'b100, 32'hFFF, 32'h0,       1'b0, 32'h0000000B, 0, 1'b0);
        issue("noise_lw", 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 0, 1'b1);
        issue("sw_20",    1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'hDEAD55EF, 0, 1'b0);

        // Reset during WAIT aborts the store.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.write_enable = 1'b1;
        bus.mode         = 3'b010;
        bus.address      = 32'h20;
        bus.write_data   = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        n_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.active) n_bad++;
        end
        chk("abort_quiet", 32'(n_bad), 32'h0);
        chk("abort_rd_zero", bus.read_data, 32'h0);
        issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 0, 1'b0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst              = 1'b1;
        bus.start        = 1'b1;
        bus.write_enable = 1'b0;
        bus.mode         = 3'b010;
        bus.address      = 32'h10;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        n_bad     = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.active) n_bad++;
        end
        chk("rst_start_quiet", 32'(n_bad), 32'h0);

        issue("sw_0c", 1'b1, 3'b010, 32'h0C, 32'hAABBCCDD, 1'b0, 32'h0, 0, 1'b0);
`ifdef MEMORY_RESPONDER_MISALIGNED_EN
        issue("sw_0e",  1'b1, 3'b010, 32'h0E, 32'h11223344, 1'b0, 32'h00000000, 1, 1'b0);
        issue("lw_0c",  1'b0, 3'b010, 32'h0C, 32'h0,        1'b0, 32'h3344CCDD, 0, 1'b0);
        issue("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEAD1122, 0, 1'b0);
        issue("lw_0e",  1'b0, 3'b010, 32'h0E, 32'h0,        1'b0, 32'h11223344, 1, 1'b0);
        issue("lh_0f",  1'b0, 3'b001, 32'h0F, 32'h0,        1'b0, 32'h00002233, 1, 1'b0);
        issue("lh_0d",  1'b0, 3'b001, 32'h0D, 32'h0,        1'b0, 32'h000044CC, 0, 1'b0);
`else
        issue("sw_0e",  1'b1, 3'b010, 32'h0E, 32'h11223344, 1'b1, 32'h00000000, 0, 1'b0);
        issue("lw_0c",  1'b0, 3'b010, 32'h0C, 32'h0,        1'b0, 32'hAABBCCDD, 0, 1'b0);
        issue("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 0, 1'b0);
        issue("lh_0d",  1'b0, 3'b001, 32'h0D, 32'h0,        1'b1, 32'hDEAD55EF, 0, 1'b0);
        issue("lw_12",  1'b0, 3'b010, 32'h12, 32'h0,        1'b1, 32'hDEAD55EF, 0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
